// File: rtl/dz_pkg.sv
// Shared types and constants for the egg-hatch dot-matrix frame path.
package dz_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PROGRESS,
      HATCH,
      ANIMAL,
      FAIL
   } dz_state_t;

   localparam logic [1:0] COL_OFF   = 2'b00;
   localparam logic [1:0] COL_RED   = 2'b01;
   localparam logic [1:0] COL_GREEN = 2'b10;

   // x^8+x^6+x^5+x^4+1: bit i set means register stage i+1 feeds the XOR.
   localparam logic [7:0] LFSR_TAPS_8 = 8'hB8;

endpackage

// File: rtl/dz_lfsr.sv
// Free-running Fibonacci LFSR; advances every cycle and never reaches zero
// from a non-zero seed.
module dz_lfsr import dz_pkg::*; #(
   parameter int                LFSR_W    = 8,
   parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(8'hA5),
   parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(LFSR_TAPS_8)
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [LFSR_W-1:0] q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[LFSR_W-2:0], ^(q & TAPS)};
      end
   end

endmodule

// File: rtl/dz_frame_ctrl.sv
// Frame controller for the egg-hatch display: maps progress to images, rolls
// an animal on hatch, blinks it, then holds it. All outputs are registered.
module dz_frame_ctrl import dz_pkg::*; #(
   parameter int                STAGES      = 16,
   parameter int                PROG_FRAMES = 8,
   parameter int                NUM_ANIMALS = 4,
   parameter int                FRAME_W     = 4,
   parameter int                BLINK_HALF  = 4,
   parameter int                BLINK_COUNT = 3,
   parameter int                LFSR_W      = 8,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = LFSR_W'(8'hA5)
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           load,
   input  logic                           fail,
   input  logic [$clog2(STAGES):0]        dz_num,
   output logic [FRAME_W-1:0]             frame_idx,
   output logic [1:0]                     colour,
   output logic                           blank,
   output logic                           frame_upd,
   output logic [$clog2(NUM_ANIMALS)-1:0] animal_id,
   output logic                           busy
);

   localparam int N_W    = $clog2(STAGES) + 1;
   localparam int AID_W  = $clog2(NUM_ANIMALS);
   localparam int SHIFT  = $clog2(STAGES) - $clog2(PROG_FRAMES);
   localparam int HALF_W = $clog2(BLINK_HALF + 1);
   localparam int PER_W  = $clog2(2 * BLINK_COUNT + 1);

   localparam logic [FRAME_W-1:0] FAIL_FRAME = FRAME_W'(PROG_FRAMES + NUM_ANIMALS);
   localparam logic [N_W-1:0]     N_MAX      = N_W'(STAGES);
   localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(BLINK_HALF - 1);
   localparam logic [PER_W-1:0]   PER_LAST   = PER_W'(2 * BLINK_COUNT - 1);

   logic [LFSR_W-1:0]  lfsr_q;
   logic [N_W-1:0]     n;
   logic               hatch_req;
   logic [AID_W-1:0]   roll;
   logic [FRAME_W-1:0] prog_frame;

   dz_state_t          state, state_n;
   logic [FRAME_W-1:0] frame_n;
   logic [1:0]         colour_n;
   logic               blank_n, busy_n, upd_n;
   logic [AID_W-1:0]   animal_n;
   logic [HALF_W-1:0]  half_cnt, half_n;
   logic [PER_W-1:0]   per_cnt, per_n;
   logic               go_hatch, go_prog;

   dz_lfsr #(
      .LFSR_W    (LFSR_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .q     (lfsr_q)
   );

   assign n          = (dz_num > N_MAX) ? N_MAX : dz_num;
   assign hatch_req  = (n == N_MAX);
   assign roll       = AID_W'(lfsr_q);
   assign prog_frame = FRAME_W'(n >> SHIFT);

   always_comb begin
      state_n  = state;
      frame_n  = frame_idx;
      colour_n = colour;
      blank_n  = blank;
      busy_n   = busy;
      animal_n = animal_id;
      half_n   = half_cnt;
      per_n    = per_cnt;
      go_hatch = 1'b0;
      go_prog  = 1'b0;

      if (load && fail) begin
         state_n  = FAIL;
         frame_n  = FAIL_FRAME;
         colour_n = COL_GREEN;
         blank_n  = 1'b0;
         busy_n   = 1'b0;
         half_n   = '0;
         per_n    = '0;
      end else begin
         unique case (state)
            IDLE, PROGRESS, FAIL: begin
               if (load) begin
                  go_hatch = hatch_req;
                  go_prog  = !hatch_req;
               end
            end
            // A finished animal is only replaced by a new egg, never re-rolled.
            ANIMAL: go_prog = load && !hatch_req;
            HATCH: begin
               if (half_cnt == HALF_LAST) begin
                  half_n = '0;
                  if (per_cnt == PER_LAST) begin
                     state_n = ANIMAL;
                     blank_n = 1'b0;
                     busy_n  = 1'b0;
                     per_n   = '0;
                  end else begin
                     per_n   = per_cnt + 1'b1;
                     blank_n = !blank;
                  end
               end else begin
                  half_n = half_cnt + 1'b1;
               end
            end
            default: state_n = IDLE;
         endcase
      end

      if (go_prog) begin
         state_n  = PROGRESS;
         frame_n  = prog_frame;
         colour_n = COL_RED;
         blank_n  = 1'b0;
      end

      if (go_hatch) begin
         state_n  = HATCH;
         animal_n = roll;
         frame_n  = FRAME_W'(PROG_FRAMES) + FRAME_W'(roll);
         colour_n = COL_RED;
         blank_n  = 1'b0;
         busy_n   = 1'b1;
         half_n   = '0;
         per_n    = '0;
      end

      upd_n = (frame_n != frame_idx) || (colour_n != colour) || (blank_n != blank);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_idx <= '0;
         colour    <= COL_OFF;
         blank     <= 1'b1;
         frame_upd <= 1'b0;
         animal_id <= '0;
         busy      <= 1'b0;
         half_cnt  <= '0;
         per_cnt   <= '0;
      end else begin
         state     <= state_n;
         frame_idx <= frame_n;
         colour    <= colour_n;
         blank     <= blank_n;
         frame_upd <= upd_n;
         animal_id <= animal_n;
         busy      <= busy_n;
         half_cnt  <= half_n;
         per_cnt   <= per_n;
      end
   end

endmodule

// File: tb/tb_dz_frame_ctrl.sv
// Self-checking bench for dz_frame_ctrl: vector table, directed hatch/fail/reset
// sequences, and random traffic against a behavioural model.
module tb_dz_frame_ctrl;

   localparam int STAGES      = 16;
   localparam int PROG_FRAMES = 8;
   localparam int NUM_ANIMALS = 4;
   localparam int BLINK_HALF  = 4;
   localparam int BLINK_COUNT = 3;
   localparam int HATCH_LEN   = 2 * BLINK_COUNT * BLINK_HALF;
   localparam int FAIL_FRAME  = PROG_FRAMES + NUM_ANIMALS;
   localparam int NV          = 11;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic       fail;
   logic [4:0] dz_num;
   logic [3:0] frame_idx;
   logic [1:0] colour;
   logic       blank;
   logic       frame_upd;
   logic [1:0] animal_id;
   logic       busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       ld;
      logic       fl;
      logic [4:0] dz;
      logic [3:0] f;
      logic [1:0] c;
      logic       b;
      logic       u;
   } vec_t;
   vec_t tbl[NV];

   typedef enum {M_IDLE, M_PROG, M_HATCH, M_ANIMAL, M_FAIL} mode_t;
   mode_t      m_mode;
   logic [7:0] m_lfsr;
   int         m_frame, m_colour, m_blank, m_upd, m_busy, m_aid, m_t;

   always #5 clk = ~clk;

   dz_frame_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .fail      (fail),
      .dz_num    (dz_num),
      .frame_idx (frame_idx),
      .colour    (colour),
      .blank     (blank),
      .frame_upd (frame_upd),
      .animal_id (animal_id),
      .busy      (busy)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Polynomial x^8+x^6+x^5+x^4+1, shifting toward the MSB.
   function automatic logic [7:0] lfsr_next(input logic [7:0] v);
      return {v[6:0], v[8-1] ^ v[6-1] ^ v[5-1] ^ v[4-1]};
   endfunction

   task automatic model_reset();
      m_mode   = M_IDLE;
      m_lfsr   = 8'hA5;
      m_frame  = 0;
      m_colour = 0;
      m_blank  = 1;
      m_upd    = 0;
      m_busy   = 0;
      m_aid    = 0;
      m_t      = 0;
   endtask

   task automatic model_step(input logic l, input logic f, input logic [4:0] d);
      int    n, pf, pc, pb;
      mode_t mode0;
      n     = (int'(d) > STAGES) ? STAGES : int'(d);
      pf    = m_frame;
      pc    = m_colour;
      pb    = m_blank;
      mode0 = m_mode;
      if (l && f) begin
         m_mode = M_FAIL; m_frame = FAIL_FRAME; m_colour = 2; m_blank = 0; m_busy = 0;
      end else if (mode0 == M_HATCH) begin
         m_t++;
         if (m_t >= HATCH_LEN) begin
            m_mode = M_ANIMAL; m_blank = 0; m_busy = 0;
         end else begin
            m_blank = (m_t / BLINK_HALF) % 2;
         end
      end else if (l) begin
         if (n == STAGES && mode0 != M_ANIMAL) begin
            m_mode   = M_HATCH;
            m_aid    = int'(m_lfsr) % NUM_ANIMALS;
            m_frame  = PROG_FRAMES + m_aid;
            m_colour = 1; m_blank = 0; m_busy = 1; m_t = 0;
         end else if (n < STAGES) begin
            m_mode   = M_PROG;
            m_frame  = n / (STAGES / PROG_FRAMES);
            m_colour = 1; m_blank = 0;
         end
      end
      m_upd  = (m_frame != pf || m_colour != pc || m_blank != pb) ? 1 : 0;
      m_lfsr = lfsr_next(m_lfsr);
   endtask

   task automatic compare_model();
      chk("model_frame_idx", int'(frame_idx), m_frame);
      chk("model_colour",    int'(colour),    m_colour);
      chk("model_blank",     int'(blank),     m_blank);
      chk("model_frame_upd", int'(frame_upd), m_upd);
      chk("model_animal_id", int'(animal_id), m_aid);
      chk("model_busy",      int'(busy),      m_busy);
   endtask

   // Called at a falling edge; returns at the next falling edge after checking.
   task automatic cycle(input logic l, input logic f, input logic [4:0] d);
      load   = l;
      fail   = f;
      dz_num = d;
      @(posedge clk);
      model_step(l, f, d);
      @(negedge clk);
      compare_model();
      load = 1'b0;
      fail = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_frame_idx"}, int'(frame_idx), 0);
      chk({tag, "_colour"},    int'(colour),    0);
      chk({tag, "_blank"},     int'(blank),     1);
      chk({tag, "_frame_upd"}, int'(frame_upd), 0);
      chk({tag, "_animal_id"}, int'(animal_id), 0);
      chk({tag, "_busy"},      int'(busy),      0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            ld    fl    dz      frame  colour b     upd
      tbl[0]  = '{1'b1, 1'b0, 5'd0,  4'd0,  2'd1, 1'b0, 1'b1};
      tbl[1]  = '{1'b0, 1'b0, 5'd0,  4'd0,  2'd1, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 5'd7,  4'd3,  2'd1, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 1'b0, 5'd15, 4'd7,  2'd1, 1'b0, 1'b1};
      tbl[4]  = '{1'b1, 1'b0, 5'd15, 4'd7,  2'd1, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 5'd14, 4'd7,  2'd1, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 5'd5,  4'd12, 2'd2, 1'b0, 1'b1};
      tbl[7]  = '{1'b1, 1'b1, 5'd16, 4'd12, 2'd2, 1'b0, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 5'd3,  4'd1,  2'd1, 1'b0, 1'b1};
      tbl[9]  = '{1'b0, 1'b1, 5'd0,  4'd1,  2'd1, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 1'b0, 5'd1,  4'd0,  2'd1, 1'b0, 1'b1};

      rst_n  = 1'b0;
      load   = 1'b0;
      fail   = 1'b0;
      dz_num = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         cycle(tbl[i].ld, tbl[i].fl, tbl[i].dz);
         chk("tbl_frame_idx", int'(frame_idx), int'(tbl[i].f));
         chk("tbl_colour",    int'(colour),    int'(tbl[i].c));
         chk("tbl_blank",     int'(blank),     int'(tbl[i].b));
         chk("tbl_frame_upd", int'(frame_upd), int'(tbl[i].u));
      end

      // Hatch when the generator reads 8'h06: animal 2, frame 10, then blink.
      for (int g = 0; g < 300 && m_lfsr != 8'h06; g++) cycle(1'b0, 1'b0, 5'd0);
      cycle(1'b1, 1'b0, 5'd16);
      chk("hatch_animal_id", int'(animal_id), 2);
      chk("hatch_frame_idx", int'(frame_idx), 10);
      chk("hatch_busy",      int'(busy),      1);
      chk("hatch_blank",     int'(blank),     0);
      for (int i = 1; i <= HATCH_LEN; i++) begin
         cycle(logic'(i == 5), 1'b0, 5'd0);
         chk("blink_frame_idx", int'(frame_idx), 10);
         chk("blink_blank", int'(blank), (i < HATCH_LEN) ? (i / BLINK_HALF) % 2 : 0);
         chk("blink_busy",  int'(busy),  (i < HATCH_LEN) ? 1 : 0);
         chk("blink_upd",   int'(frame_upd), (i % BLINK_HALF == 0) ? 1 : 0);
      end

      // ANIMAL ignores a second hatch load, a new egg returns to progress.
      cycle(1'b1, 1'b0, 5'd16);
      chk("animal_hold_frame", int'(frame_idx), 10);
      chk("animal_hold_upd",   int'(frame_upd), 0);
      chk("animal_hold_id",    int'(animal_id), 2);
      cycle(1'b1, 1'b0, 5'd0);
      chk("new_egg_frame", int'(frame_idx), 0);
      chk("new_egg_upd",   int'(frame_upd), 1);

      // Fail aborts a hatch at cycle 9, then progress resumes.
      cycle(1'b1, 1'b0, 5'd16);
      for (int i = 1; i <= 8; i++) cycle(1'b0, 1'b0, 5'd0);
      cycle(1'b1, 1'b1, 5'd0);
      chk("abort_frame_idx", int'(frame_idx), FAIL_FRAME);
      chk("abort_colour",    int'(colour),    2);
      chk("abort_blank",     int'(blank),     0);
      chk("abort_busy",      int'(busy),      0);
      cycle(1'b1, 1'b0, 5'd3);
      chk("after_fail_frame",  int'(frame_idx), 1);
      chk("after_fail_colour", int'(colour),    1);

      // Over-range count is clamped to a hatch.
      cycle(1'b1, 1'b0, 5'd20);
      chk("clamp_busy",   int'(busy),   1);
      chk("clamp_colour", int'(colour), 1);

      // Asynchronous reset mid-blink, then the seed roll is 8'hA5 -> animal 1.
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 5'd0);
      #2 rst_n = 1'b0;
      #1 check_reset_vals("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      cycle(1'b1, 1'b0, 5'd16);
      chk("seed_roll_id",    int'(animal_id), 1);
      chk("seed_roll_frame", int'(frame_idx), 9);

      for (int k = 0; k < 2000; k++) begin
         logic       l, f;
         logic [4:0] d;
         l = ($urandom_range(0, 2) == 0);
         f = ($urandom_range(0, 7) == 0);
         d = ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 24));
         cycle(l, f, d);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
